// File: rtl/fixed_to_bcd.sv
// Converts a signed Q18.14 fixed-point value into sign + 6 integer BCD digits + 4 truncated fraction BCD digits.
// Integer part uses double dabble (18 cycles), fraction uses repeated multiply-by-10 (4 cycles).

// state     | meaning
// IDLE      | waiting for start; outputs hold last result
// CONV_INT  | shifting integer bits MSB first through the BCD digits
// CONV_FRAC | emitting one fraction digit per cycle, tenths first
module fixed_to_bcd (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        overflow_in,
  output logic        busy,
  output logic        done,
  output logic        sign,
  output logic [23:0] int_bcd,
  output logic [15:0] frac_bcd,
  output logic        ovf_flag
);

  typedef enum logic [1:0] {IDLE, CONV_INT, CONV_FRAC} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic        cnt_tc;
  logic        capture, finish;
  logic [31:0] mag;
  logic [17:0] int_sh;
  logic [13:0] frac_sh;
  logic [23:0] int_work;
  logic [23:0] int_adj;
  logic [15:0] frac_work;
  logic [15:0] frac_final;
  logic [17:0] prod;
  logic [3:0]  digit;
  logic        neg, ovf_cap;

  // 0x80000000 negates to itself, which is the intended unsigned magnitude
  assign mag        = value[31] ? (~value + 32'd1) : value;
  assign cnt_tc     = (cnt == 5'd0);
  assign busy       = (state != IDLE);
  assign prod       = {4'd0, frac_sh} * 18'd10;
  assign digit      = prod[17:14];
  assign frac_final = {frac_work[11:0], digit};

  always_comb begin
    int_adj = int_work;
    for (int i = 0; i < 6; i++) begin
      if (int_work[4*i +: 4] >= 4'd5)
        int_adj[4*i +: 4] = int_work[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = CONV_INT;
        end
      end
      CONV_INT: begin
        if (cnt_tc) state_next = CONV_FRAC;
      end
      CONV_FRAC: begin
        if (cnt_tc) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 5'd0;
      int_sh    <= 18'd0;
      frac_sh   <= 14'd0;
      int_work  <= 24'd0;
      frac_work <= 16'd0;
      neg       <= 1'b0;
      ovf_cap   <= 1'b0;
      done      <= 1'b0;
      sign      <= 1'b0;
      int_bcd   <= 24'd0;
      frac_bcd  <= 16'd0;
      ovf_flag  <= 1'b0;
    end else begin
      done <= finish;
      if (capture) begin
        int_sh    <= mag[31:14];
        frac_sh   <= mag[13:0];
        neg       <= value[31];
        ovf_cap   <= overflow_in;
        int_work  <= 24'd0;
        frac_work <= 16'd0;
        cnt       <= 5'd17;
      end else if (state == CONV_INT) begin
        // top digit never exceeds 1, so dropping int_adj[23] loses nothing
        int_work <= {int_adj[22:0], int_sh[17]};
        int_sh   <= {int_sh[16:0], 1'b0};
        cnt      <= cnt_tc ? 5'd3 : cnt - 5'd1;
      end else if (state == CONV_FRAC) begin
        frac_work <= frac_final;
        frac_sh   <= prod[13:0];
        if (!cnt_tc) cnt <= cnt - 5'd1;
      end
      if (finish) begin
        int_bcd  <= int_work;
        frac_bcd <= frac_final;
        sign     <= neg & ((|int_work) | (|frac_final));
        ovf_flag <= ovf_cap;
      end
    end
  end

endmodule

// File: tb/tb_fixed_to_bcd.sv
// Scoreboard bench for fixed_to_bcd: driver pushes expected results from an arithmetic model,
// monitor pops and compares on every done pulse and checks outputs hold in between.
module tb_fixed_to_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'd0;
  logic        overflow_in = 1'b0;
  logic        busy, done, sign, ovf_flag;
  logic [23:0] int_bcd;
  logic [15:0] frac_bcd;

  fixed_to_bcd dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .overflow_in(overflow_in),
    .busy(busy), .done(done), .sign(sign), .int_bcd(int_bcd), .frac_bcd(frac_bcd),
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [23:0] ib;
    logic [15:0] fb;
    logic        s;
    logic        o;
    int          cap;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] disp_ib = 24'd0;
  logic [15:0] disp_fb = 16'd0;
  logic        disp_s  = 1'b0;
  logic        disp_o  = 1'b0;

  function automatic exp_t model(input logic [31:0] v, input logic ovf, input int cap);
    exp_t   e;
    longint sv, m, ip, fp, f4, t;
    sv = longint'($signed(v));
    m  = (sv < 0) ? -sv : sv;
    ip = m / 16384;
    fp = m % 16384;
    f4 = (fp * 10000) / 16384;
    e.ib = 24'd0;
    e.fb = 16'd0;
    t = ip;
    for (int i = 0; i < 6; i++) begin
      e.ib[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    t = f4;
    for (int i = 0; i < 4; i++) begin
      e.fb[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.s   = (sv < 0) && (ip != 0 || f4 != 0);
    e.o   = ovf;
    e.cap = cap;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      disp_ib = 24'd0; disp_fb = 16'd0; disp_s = 1'b0; disp_o = 1'b0;
      check("reset_ctrl", {62'd0, busy, done}, 64'd0);
      check("reset_outputs", {sign, ovf_flag, int_bcd, frac_bcd}, {disp_s, disp_o, disp_ib, disp_fb});
    end else if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency", 64'(cyc - e.cap), 64'd22);
        check("int_bcd", 64'(int_bcd), 64'(e.ib));
        check("frac_bcd", 64'(frac_bcd), 64'(e.fb));
        check("sign", 64'(sign), 64'(e.s));
        check("ovf_flag", 64'(ovf_flag), 64'(e.o));
        disp_ib = e.ib; disp_fb = e.fb; disp_s = e.s; disp_o = e.o;
      end
    end else begin
      check("outputs_hold", {sign, ovf_flag, int_bcd, frac_bcd}, {disp_s, disp_o, disp_ib, disp_fb});
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    if (k == 40) check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic run_conv(input logic [31:0] v, input logic ovf);
    @(negedge clk);
    start = 1'b1; value = v; overflow_in = ovf;
    sb.push_back(model(v, ovf, cyc + 1));
    @(negedge clk);
    start = 1'b0; value = $urandom; overflow_in = 1'($urandom);
    check("busy_after_capture", 64'(busy), 64'd1);
    repeat ($urandom_range(1, 12)) @(negedge clk);
    start = 1'b1; value = $urandom;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_back_to_back(input logic [31:0] a, input logic [31:0] b, input logic ob);
    int cap1;
    @(negedge clk);
    start = 1'b1; value = a; overflow_in = 1'b0;
    cap1 = cyc + 1;
    sb.push_back(model(a, 1'b0, cap1));
    @(negedge clk);
    value = b; overflow_in = ob;
    sb.push_back(model(b, ob, cap1 + 23));
    repeat (23) @(negedge clk);
    start = 1'b0;
    check("b2b_second_busy", 64'(busy), 64'd1);
    wait_idle();
  endtask

  task automatic run_reset_abort();
    @(negedge clk);
    start = 1'b1; value = 32'h0000_4000; overflow_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; value = 32'h0000_8000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    run_conv(32'h0000_8000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    run_conv(32'h0000_4000, 1'b0);
    run_conv(32'hFFFF_E000, 1'b0);
    run_conv(32'h0000_C90F, 1'b0);
    run_conv(32'h7FFF_FFFF, 1'b0);
    run_conv(32'h8000_0000, 1'b0);
    run_conv(32'hFFFF_FFFF, 1'b1);
    run_conv(32'h0000_0000, 1'b0);
    run_back_to_back(32'h0000_C90F, 32'hFFFF_E000, 1'b1);
    run_reset_abort();
    for (int i = 0; i < 40; i++) run_conv($urandom, 1'($urandom));
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1000000 ns");
    $fatal(1, "watchdog");
  end

endmodule
